// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Also holds the helper that decides whether an op code occupies the iterator.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    localparam int MD_ITER = 32;

    // Ops that occupy the iterator; MTHI/MTLO and the reserved codes do not.
    function automatic logic isMultiCycle(input logic [2:0] opCode);
        return (opCode == MD_MULT) || (opCode == MD_MULTU) ||
               (opCode == MD_DIV)  || (opCode == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sign_adjust.sv
// Turns the unsigned magnitude result of the iterator into the architectural HI/LO
// values: two's-complement sign fix-up plus the divide-by-zero forced result.
module md_sign_adjust
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_ITER
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] magHi_i,
    input  logic [XLEN-1:0] magLo_i,
    input  logic            signA_i,
    input  logic            signB_i,
    input  logic            divZero_i,
    input  logic [XLEN-1:0] aRaw_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            dbz_o
);

    logic                  negResult;
    logic [2*XLEN-1:0]     product;

    assign negResult = signA_i ^ signB_i;

    // Sign flags are only ever set for signed ops, so unsigned ops pass through untouched.
    always_comb begin
        hi_o    = magHi_i;
        lo_o    = magLo_i;
        dbz_o   = 1'b0;
        product = {magHi_i, magLo_i};
        case (op_i)
            MD_MULT, MD_MULTU: begin
                if (negResult) begin
                    product = -product;
                end
                hi_o = product[2*XLEN-1:XLEN];
                lo_o = product[XLEN-1:0];
            end
            MD_DIV, MD_DIVU: begin
                if (divZero_i) begin
                    lo_o  = '1;
                    hi_o  = aRaw_i;
                    dbz_o = 1'b1;
                end else begin
                    lo_o = negResult ? -magLo_i : magLo_i;
                    hi_o = signA_i   ? -magHi_i : magHi_i;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 shift-add multiplier / restoring divider owning the HI/LO registers.
// One result bit per cycle: IDLE -> RUN (XLEN cycles) -> FIX (sign fix-up, HI/LO load).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            dbz,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    md_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] aRaw_q, aRaw_d;
    md_op_t          opCode_q, opCode_d;
    logic            signA_q, signA_d;
    logic            signB_q, signB_d;
    logic            divZero_q, divZero_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    md_op_t          opIn;
    logic            signedIn, divIn, aNeg, bNeg, divRun;
    logic [XLEN-1:0] magA, magB;
    logic [XLEN:0]   mulSum, divShift;
    logic [XLEN-1:0] adjHi, adjLo;
    logic            adjDbz;

    assign opIn     = md_op_t'(op);
    assign signedIn = (opIn == MD_MULT) || (opIn == MD_DIV);
    assign divIn    = (opIn == MD_DIV) || (opIn == MD_DIVU);
    assign aNeg     = signedIn & a[XLEN-1];
    assign bNeg     = signedIn & b[XLEN-1];
    assign magA     = aNeg ? -a : a;
    assign magB     = bNeg ? -b : b;
    assign divRun   = (opCode_q == MD_DIV) || (opCode_q == MD_DIVU);

    // Multiply: {acc, mq} shifts right with the carry-out of the conditional add.
    // Divide: {acc, mq} shifts left; acc is the partial remainder, mq collects quotient bits.
    assign mulSum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    assign divShift = {acc_q, mq_q[XLEN-1]};

    md_sign_adjust #(.XLEN(XLEN)) u_sign_adjust (
        .op_i      (opCode_q),
        .magHi_i   (acc_q),
        .magLo_i   (mq_q),
        .signA_i   (signA_q),
        .signB_i   (signB_q),
        .divZero_i (divZero_q),
        .aRaw_i    (aRaw_q),
        .hi_o      (adjHi),
        .lo_o      (adjLo),
        .dbz_o     (adjDbz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            aRaw_q    <= '0;
            opCode_q  <= MD_MULT;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            aRaw_q    <= aRaw_d;
            opCode_q  <= opCode_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // A flush always beats whatever the current state would otherwise do, including a start in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        aRaw_d    = aRaw_q;
        opCode_d  = opCode_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (opIn)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d   = RUN;
                            cnt_d     = '0;
                            acc_d     = '0;
                            mq_d      = divIn ? magA : magB;
                            opnd_d    = divIn ? magB : magA;
                            aRaw_d    = a;
                            opCode_d  = opIn;
                            signA_d   = aNeg;
                            signB_d   = bNeg;
                            divZero_d = (b == '0);
                        end
                        MD_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        MD_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            RUN: begin
                if (divRun) begin
                    if (divShift >= {1'b0, opnd_q}) begin
                        acc_d = divShift[XLEN-1:0] - opnd_q;
                        mq_d  = {mq_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = divShift[XLEN-1:0];
                        mq_d  = {mq_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mulSum[XLEN:1];
                    mq_d  = {mulSum[0], mq_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d   = adjHi;
                    lo_d   = adjLo;
                    dbz_d  = adjDbz;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy | (start & (state_q == IDLE) & isMultiCycle(op));
    assign done  = done_q;
    assign dbz   = dbz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of hand-computed ops checked for exact
// cycle timing and HI/LO/dbz results, then hand-written flush/reset/overlap sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        startIn;
    logic [2:0]  opIn;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        flushIn;
    logic        busy, stall, done, dbz;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    vec_t vecs[15];

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (startIn),
        .op    (opIn),
        .a     (aIn),
        .b     (bIn),
        .flush (flushIn),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issues one op at cycle N and checks the full timing profile up to N+35.
    task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input logic expDbz);
        logic multi;
        logic busyOk;
        multi   = (op < 3'd4);
        startIn = 1'b1;
        opIn    = op;
        aIn     = a;
        bIn     = b;
        #1;
        checkOutput($sformatf("v%0d stall at issue", idx), {31'd0, stall}, {31'd0, multi});
        waitCycle();
        startIn = 1'b0;
        if (multi) begin
            busyOk = 1'b1;
            for (int k = 1; k <= 33; k++) begin
                if (!(busy === 1'b1 && done === 1'b0 && stall === 1'b1)) busyOk = 1'b0;
                waitCycle();
            end
            checkOutput($sformatf("v%0d busy profile N+1..N+33", idx), {31'd0, busyOk}, 32'd1);
        end
        checkOutput($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
        checkOutput($sformatf("v%0d busy at done", idx), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("v%0d hi", idx), hi, expHi);
        checkOutput($sformatf("v%0d lo", idx), lo, expLo);
        checkOutput($sformatf("v%0d dbz", idx), {31'd0, dbz}, {31'd0, expDbz});
        waitCycle();
        checkOutput($sformatf("v%0d done one-shot", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int doneCnt;

        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{MD_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{MD_MTLO,  32'h00001234, 32'd0,        32'd5,        32'h00001234, 1'b0};
        vecs[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        vecs[9]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{MD_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[12] = '{MD_MTHI,  32'h0000CAFE, 32'd0,        32'h0000CAFE, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[14] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        rst     = 1'b1;
        startIn = 1'b0;
        opIn    = 3'd0;
        aIn     = '0;
        bIn     = '0;
        flushIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset dbz", {31'd0, dbz}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        waitCycle();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].expDbz);
        end

        // Second start (an MTHI that would clobber hi) at N+5 must be ignored.
        startIn = 1'b1; opIn = MD_MULTU; aIn = 32'd3; bIn = 32'd5;
        waitCycle();
        startIn = 1'b0; opIn = MD_MTHI; aIn = 32'h0000DEAD;
        doneCnt = 0;
        for (int k = 1; k <= 40; k++) begin
            startIn = (k == 5);
            #1;
            if (done === 1'b1) doneCnt++;
            waitCycle();
        end
        startIn = 1'b0;
        checkOutput("overlap done count", doneCnt, 32'd1);
        checkOutput("overlap hi", hi, 32'd0);
        checkOutput("overlap lo", lo, 32'd15);

        // Flush at N+10 cancels the multiply with no done and no HI/LO change.
        startIn = 1'b1; opIn = MD_MULTU; aIn = 32'd6; bIn = 32'd7;
        waitCycle();
        startIn = 1'b0;
        repeat (9) waitCycle();
        flushIn = 1'b1;
        waitCycle();
        flushIn = 1'b0;
        checkOutput("flush busy N+11", {31'd0, busy}, 32'd0);
        doneCnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) doneCnt++;
            waitCycle();
        end
        checkOutput("flush done count", doneCnt, 32'd0);
        checkOutput("flush hi", hi, 32'd0);
        checkOutput("flush lo", lo, 32'd15);

        // Asynchronous reset at N+7 clears everything without waiting for a clock edge.
        startIn = 1'b1; opIn = MD_DIVU; aIn = 32'd100; bIn = 32'd7;
        waitCycle();
        startIn = 1'b0;
        repeat (6) waitCycle();
        rst = 1'b1;
        #1;
        checkOutput("midop reset hi", hi, 32'd0);
        checkOutput("midop reset lo", lo, 32'd0);
        checkOutput("midop reset busy", {31'd0, busy}, 32'd0);
        checkOutput("midop reset done", {31'd0, done}, 32'd0);
        waitCycle();
        rst = 1'b0;
        waitCycle();

        // Flush together with start in IDLE drops the start.
        applyStimulus(100, MD_MTLO, 32'h55, 32'd0, 32'd0, 32'h55, 1'b0);
        startIn = 1'b1; flushIn = 1'b1; opIn = MD_MULTU; aIn = 32'd9; bIn = 32'd9;
        waitCycle();
        startIn = 1'b0; flushIn = 1'b0;
        checkOutput("flush+start busy", {31'd0, busy}, 32'd0);
        doneCnt = 0;
        for (int k = 0; k < 36; k++) begin
            if (done === 1'b1) doneCnt++;
            waitCycle();
        end
        checkOutput("flush+start done count", doneCnt, 32'd0);
        checkOutput("flush+start lo", lo, 32'h55);
        startIn = 1'b1; flushIn = 1'b1; opIn = MD_MTHI; aIn = 32'h777;
        waitCycle();
        startIn = 1'b0; flushIn = 1'b0;
        checkOutput("flush+mthi done", {31'd0, done}, 32'd0);
        checkOutput("flush+mthi hi", hi, 32'd0);

        // Reserved op code is ignored entirely.
        startIn = 1'b1; opIn = 3'd6; aIn = 32'hABCD; bIn = 32'd1;
        #1;
        checkOutput("reserved stall", {31'd0, stall}, 32'd0);
        waitCycle();
        startIn = 1'b0;
        checkOutput("reserved busy", {31'd0, busy}, 32'd0);
        checkOutput("reserved done", {31'd0, done}, 32'd0);
        checkOutput("reserved hi", hi, 32'd0);
        checkOutput("reserved lo", lo, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
